// File: rtl/olo_intf_button_events_pkg.sv
`default_nettype none
// ============================================================================
// Module   : olo_intf_button_events_pkg
// Brief    : Shared types and elaboration-time helpers for the button events.
// Revision : 1.0 - initial release
// ============================================================================
package olo_intf_button_events_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_t;

    // TickCycles when is_cycles=1, otherwise a hold time expressed in ticks.
    function automatic int calc_ticks(input real value, input real tick_period, input bit is_cycles);
        real r_val;
        if (is_cycles) begin
            r_val = value * tick_period;
        end else begin
            r_val = value / tick_period;
        end
        return $rtoi(r_val + 0.5);
    endfunction

    function automatic int log2ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/olo_intf_button_events_tick.sv
`default_nettype none
// ============================================================================
// Module   : olo_intf_button_events_tick
// Brief    : Free-running prescaler producing a one-cycle tick every TickCycles.
// Revision : 1.0 - initial release
// ============================================================================
module olo_intf_button_events_tick
    import olo_intf_button_events_pkg::*;
#(
    parameter int TickCycles = 125000
) (
    input  logic Clk,
    input  logic Rst,
    output logic Tick
);

    localparam int                c_CNT_W = (log2ceil(TickCycles) < 1) ? 1 : log2ceil(TickCycles);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TickCycles - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/olo_intf_button_events.sv
`default_nettype none
// ============================================================================
// Module   : olo_intf_button_events
// Brief    : Per-channel Press/Release/LongPress/Repeat strobe generator.
// Revision : 1.0 - initial release
// ============================================================================
module olo_intf_button_events
    import olo_intf_button_events_pkg::*;
#(
    parameter real ClkFrequency_g  = 125.0e6,
    parameter real TickPeriod_g    = 1.0e-3,
    parameter real LongPressTime_g = 1.0,
    parameter real RepeatTime_g    = 0.2,
    parameter int  Width_g         = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [Width_g-1:0] In_Buttons,
    output logic [Width_g-1:0] Out_Press,
    output logic [Width_g-1:0] Out_Release,
    output logic [Width_g-1:0] Out_LongPress,
    output logic [Width_g-1:0] Out_Repeat
);

    localparam int c_TICK_CYCLES  = calc_ticks(ClkFrequency_g, TickPeriod_g, 1'b1);
    localparam int c_LONG_TICKS   = calc_ticks(LongPressTime_g, TickPeriod_g, 1'b0);
    localparam int c_REPEAT_TICKS = calc_ticks(RepeatTime_g, TickPeriod_g, 1'b0);
    localparam int c_HOLD_MAX     = (c_LONG_TICKS > c_REPEAT_TICKS) ? c_LONG_TICKS : c_REPEAT_TICKS;
    localparam int c_CNT_W        = (log2ceil(c_HOLD_MAX) < 1) ? 1 : log2ceil(c_HOLD_MAX);

    // Thresholds compare against the pre-increment value so the strobe is
    // registered in the same cycle the counter would reach the tick count.
    localparam logic [c_CNT_W-1:0] c_LONG_LAST   = c_CNT_W'(c_LONG_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_REPEAT_LAST = c_CNT_W'(c_REPEAT_TICKS - 1);

    logic w_tick;

    olo_intf_button_events_tick #(
        .TickCycles (c_TICK_CYCLES)
    ) i_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .Tick (w_tick)
    );

    for (genvar g = 0; g < Width_g; g++) begin : g_ch
        btn_state_t         r_state;
        btn_state_t         w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic               r_last;
        logic               r_press;
        logic               r_release;
        logic               r_long;
        logic               r_repeat;
        logic               w_press_nxt;
        logic               w_release_nxt;
        logic               w_long_nxt;
        logic               w_repeat_nxt;

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_last    <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_last    <= In_Buttons[g];
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
                r_long    <= w_long_nxt;
                r_repeat  <= w_repeat_nxt;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            w_long_nxt    = 1'b0;
            w_repeat_nxt  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (In_Buttons[g] && !r_last) begin
                        w_press_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HELD;
                    end
                end
                ST_HELD: begin
                    // Release takes priority over a coincident threshold.
                    if (!In_Buttons[g]) begin
                        w_release_nxt = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt == c_LONG_LAST) begin
                            w_long_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_LONG;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (!In_Buttons[g]) begin
                        w_release_nxt = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt == c_REPEAT_LAST) begin
                            w_repeat_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign Out_Press[g]     = r_press;
        assign Out_Release[g]   = r_release;
        assign Out_LongPress[g] = r_long;
        assign Out_Repeat[g]    = r_repeat;
    end

endmodule
`default_nettype wire
